// File: rtl/lcm_seq.sv
// Sequential least-common-multiple engine: two accumulators step by X and Y
// until they meet, one addition per clock, with a Start/Busy/Done handshake.
module lcm_seq #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Lcm_output,
  output logic [2*WIDTH-1:0] Steps
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] xa_q, xa_d;
  logic [RW-1:0] yb_q, yb_d;
  logic [RW-1:0] m1_q, m1_d;
  logic [RW-1:0] m2_q, m2_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] lcm_q, lcm_d;
  logic [RW-1:0] steps_q, steps_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      xa_q    <= '0;
      yb_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      cnt_q   <= '0;
      lcm_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      cnt_q   <= cnt_d;
      lcm_q   <= lcm_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    yb_d    = yb_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    cnt_d   = cnt_q;
    lcm_d   = lcm_q;
    steps_d = steps_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          xa_d  = {{WIDTH{1'b0}}, X};
          yb_d  = {{WIDTH{1'b0}}, Y};
          m1_d  = {{WIDTH{1'b0}}, X};
          m2_d  = {{WIDTH{1'b0}}, Y};
          cnt_d = '0;
          // A zero operand would never let the accumulators meet.
          if (X == '0 || Y == '0) begin
            lcm_d   = '0;
            steps_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (m1_q < m2_q) begin
          m1_d  = m1_q + xa_q;
          cnt_d = cnt_q + 1'b1;
        end else if (m1_q > m2_q) begin
          m2_d  = m2_q + yb_q;
          cnt_d = cnt_q + 1'b1;
        end else begin
          lcm_d   = m1_q;
          steps_d = cnt_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy       = (state_q == S_RUN);
  assign Done       = (state_q == S_DONE);
  assign Lcm_output = lcm_q;
  assign Steps      = steps_q;

endmodule

// File: tb/tb_lcm_seq.sv
// Randomized self-checking bench for lcm_seq against a gcd-based lcm model.
module tb_lcm_seq;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  X;
  logic [7:0]  Y;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [15:0] Lcm_output;
  logic [15:0] Steps;

  int n_cmp;
  int n_err;

  lcm_seq #(.WIDTH(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .X          (X),
    .Y          (Y),
    .Start      (Start),
    .Busy       (Busy),
    .Done       (Done),
    .Lcm_output (Lcm_output),
    .Steps      (Steps)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: lcm from Euclid's gcd; steps = lcm/x + lcm/y - 2.
  function automatic void ref_lcm(input int x, input int y, output int l, output int s);
    int a, b, t;
    if (x == 0 || y == 0) begin
      l = 0;
      s = 0;
    end else begin
      a = x;
      b = y;
      while (b != 0) begin
        t = a % b;
        a = b;
        b = t;
      end
      l = (x / a) * y;
      s = l / x + l / y - 2;
    end
  endfunction

  // Issue one Start, optionally poke a second Start during RUN, wait for Done.
  task automatic run_op(input int x, input int y, input bit poke,
                        output int lat, output int res, output int st,
                        output bit busy_seen, output bit timed_out);
    @(negedge Clk);
    X = x[7:0];
    Y = y[7:0];
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 0;
    busy_seen = 1'b0;
    while (Done !== 1'b1 && lat < 2000) begin
      if (Busy === 1'b1) busy_seen = 1'b1;
      if (poke && lat == 1) begin
        X = 8'd3;
        Y = 8'd5;
        Start = 1'b1;
      end
      if (poke && lat == 2) Start = 1'b0;
      @(posedge Clk);
      #1;
      lat++;
    end
    Start = 1'b0;
    timed_out = (lat >= 2000);
    res = int'(Lcm_output);
    st = int'(Steps);
  endtask

  task automatic do_check(input int x, input int y, input bit poke);
    int lat, res, st, el, es;
    bit busy_seen, timed_out;
    ref_lcm(x, y, el, es);
    run_op(x, y, poke, lat, res, st, busy_seen, timed_out);
    $display("op x=%0d y=%0d lcm=%0d steps=%0d lat=%0d (exp lcm=%0d steps=%0d)",
             x, y, res, st, lat, el, es);
    check_eq("timeout", timed_out, 0);
    check_eq("lcm", res, el);
    check_eq("steps", st, es);
    if (x == 0 || y == 0) begin
      check_eq("zero_latency_le1", lat <= 1, 1);
      check_eq("zero_busy_seen", busy_seen, 0);
    end else begin
      check_eq("latency", lat, es + 1);
      check_eq("busy_seen", busy_seen, 1);
    end
    @(posedge Clk);
    #1;
    check_eq("done_one_cycle", Done, 0);
    check_eq("lcm_held", Lcm_output, el);
  endtask

  initial begin
    int d1, d2, cyc, x, y;
    n_cmp = 0;
    n_err = 0;
    Reset_n = 1'b0;
    X = '0;
    Y = '0;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_lcm", Lcm_output, 0);
    check_eq("rst_steps", Steps, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    do_check(4, 6, 1'b0);
    do_check(5, 5, 1'b0);
    do_check(0, 9, 1'b0);
    do_check(7, 0, 1'b0);
    do_check(255, 254, 1'b0);
    // Start during RUN must be ignored; the next accepted Start uses new operands.
    do_check(4, 6, 1'b1);
    do_check(3, 5, 1'b0);

    // Asynchronous reset mid-RUN of (12,18); previous result is nonzero.
    @(negedge Clk);
    X = 8'd12;
    Y = 8'd18;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_eq("abort_busy", Busy, 0);
    check_eq("abort_done", Done, 0);
    check_eq("abort_lcm", Lcm_output, 0);
    check_eq("abort_steps", Steps, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    do_check(12, 18, 1'b0);

    // Start held high: back-to-back (4,6) ops, Done pulses 6 cycles apart.
    @(negedge Clk);
    X = 8'd4;
    Y = 8'd6;
    Start = 1'b1;
    cyc = 0;
    d1 = -1;
    d2 = -1;
    while (d2 < 0 && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (Done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    Start = 1'b0;
    $display("held start: done at %0d and %0d", d1, d2);
    check_eq("held_second_done", d2 >= 0, 1);
    check_eq("held_gap", d2 - d1, 6);
    check_eq("held_lcm", Lcm_output, 12);
    repeat (8) @(posedge Clk);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 255);
      end else begin
        x = $urandom_range(0, 31);
        y = $urandom_range(0, 31);
      end
      do_check(x, y, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
